// File: rtl/data_mem_responder_if.sv
// Bus between the MEM stage (master) and the data memory responder (slave).
//   MemRead/MemWrite : request strobes, exactly one high for a legal access
//   Funct3           : RV32I access size / extension code
//   addr             : byte address
//   wd               : store data
//   rd               : registered load result
//   stall            : pipeline hold request
//   access_err       : misaligned or illegal access, valid in the DONE cycle
interface data_mem_responder_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 9
);
   logic              MemRead;
   logic              MemWrite;
   logic [2:0]        Funct3;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wd;
   logic [DATA_W-1:0] rd;
   logic              stall;
   logic              access_err;

   modport master (
      output MemRead, MemWrite, Funct3, addr, wd,
      input  rd, stall, access_err
   );

   modport slave (
      input  MemRead, MemWrite, Funct3, addr, wd,
      output rd, stall, access_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder for the MEM stage: serves RV32I byte/half/word loads
// and stores against an internal word array with a programmable access latency,
// holding the pipeline via stall until each access completes.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : data_mem_responder_if.slave (request in, rd/stall/access_err out)
module data_mem_responder #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 9,
   parameter int unsigned LATENCY = 2
) (
   input logic                   clk,
   input logic                   rst_n,
   data_mem_responder_if.slave   bus
);

   localparam int unsigned Depth = 2 ** (ADDR_W - 2);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StBusy = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              rd_en_q, rd_en_d;
   logic              wr_en_q, wr_en_d;
   logic [2:0]        f3_q, f3_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wd_q, wd_d;
   logic [DATA_W-1:0] rd_q, rd_d;
   logic              err_q, err_d;

   logic [DATA_W-1:0] mem_q [Depth];

   logic              in_idle;
   logic              req;
   logic              commit;
   logic              cur_rd, cur_wr;
   logic [2:0]        cur_f3;
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_wd;
   logic              cur_err;
   logic [ADDR_W-3:0] word_idx;
   logic [1:0]        lane;
   logic [DATA_W-1:0] mem_word;
   logic [DATA_W-1:0] shifted;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;
   logic [DATA_W-1:0] load_data;
   logic [3:0]        be;
   logic [DATA_W-1:0] wdata;
   logic              wr_fire;

   assign in_idle = (state_q == StIdle);
   assign req     = bus.MemRead | bus.MemWrite;

   // With LATENCY = 1 the access commits on its acceptance edge, so in IDLE the
   // live inputs are the access; afterwards the latched copy is used.
   assign cur_rd   = in_idle ? bus.MemRead  : rd_en_q;
   assign cur_wr   = in_idle ? bus.MemWrite : wr_en_q;
   assign cur_f3   = in_idle ? bus.Funct3   : f3_q;
   assign cur_addr = in_idle ? bus.addr     : addr_q;
   assign cur_wd   = in_idle ? bus.wd       : wd_q;

   // Edge that enters DONE: the only edge where the array and rd are updated.
   assign commit = (in_idle && req && (LATENCY == 1)) ||
                   ((state_q == StBusy) && (cnt_q == 4'd1));

   always_comb begin
      cur_err = cur_rd & cur_wr;
      case (cur_f3)
         3'b000:  ;
         3'b001:  if (cur_addr[0]) cur_err = 1'b1;
         3'b010:  if (cur_addr[1:0] != 2'b00) cur_err = 1'b1;
         3'b100:  if (cur_wr) cur_err = 1'b1;
         3'b101:  if (cur_wr || cur_addr[0]) cur_err = 1'b1;
         default: cur_err = 1'b1;
      endcase
   end

   assign word_idx = cur_addr[ADDR_W-1:2];
   assign lane     = cur_addr[1:0];
   assign mem_word = mem_q[word_idx];
   assign shifted  = mem_word >> {lane, 3'b000};
   assign byte_v   = shifted[7:0];
   assign half_v   = cur_addr[1] ? mem_word[31:16] : mem_word[15:0];

   // Funct3[2] selects zero extension (lbu/lhu).
   always_comb begin
      case (cur_f3[1:0])
         2'b00:   load_data = {{(DATA_W-8){byte_v[7] & ~cur_f3[2]}}, byte_v};
         2'b01:   load_data = {{(DATA_W-16){half_v[15] & ~cur_f3[2]}}, half_v};
         default: load_data = mem_word;
      endcase
   end

   always_comb begin
      case (cur_f3[1:0])
         2'b00: begin
            be    = 4'b0001 << lane;
            wdata = {4{cur_wd[7:0]}};
         end
         2'b01: begin
            be    = cur_addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{cur_wd[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = cur_wd;
         end
      endcase
   end

   assign wr_fire = commit & cur_wr & ~cur_err & rst_n;

   // Array is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_en_d = rd_en_q;
      wr_en_d = wr_en_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wd_d    = wd_q;
      rd_d    = rd_q;
      err_d   = 1'b0;
      case (state_q)
         StIdle: begin
            if (req) begin
               rd_en_d = bus.MemRead;
               wr_en_d = bus.MemWrite;
               f3_d    = bus.Funct3;
               addr_d  = bus.addr;
               wd_d    = bus.wd;
               cnt_d   = 4'(LATENCY - 1);
               state_d = (LATENCY == 1) ? StDone : StBusy;
            end
         end
         StBusy: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (commit) begin
         err_d = cur_err;
         if (cur_err)     rd_d = '0;
         else if (cur_rd) rd_d = load_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rd_en_q <= 1'b0;
         wr_en_q <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wd_q    <= '0;
         rd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_en_q <= rd_en_d;
         wr_en_q <= wr_en_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wd_q    <= wd_d;
         rd_q    <= rd_d;
         err_q   <= err_d;
      end
   end

   assign bus.rd         = rd_q;
   assign bus.access_err = err_q;
   assign bus.stall      = rst_n & ((in_idle & req) | (state_q == StBusy));

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2 instance driven from a vector
// table, a reset-abort sequence, and a LATENCY=1 instance back-to-back run.
module tb_data_mem_responder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   data_mem_responder_if #(.DATA_W(32), .ADDR_W(9)) if2 ();
   data_mem_responder_if #(.DATA_W(32), .ADDR_W(9)) if1 ();

   data_mem_responder #(.DATA_W(32), .ADDR_W(9), .LATENCY(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if2)
   );

   data_mem_responder #(.DATA_W(32), .ADDR_W(9), .LATENCY(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1)
   );

   typedef struct packed {
      logic        r;
      logic        w;
      logic [2:0]  f3;
      logic [8:0]  a;
      logic [31:0] d;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   typedef struct packed {
      logic [31:0] rd;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input int tag, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %h, expected %h", name, tag, act, exp);
      end
   endtask

   task automatic drive(input int lat, input logic r, input logic w, input logic [2:0] f3,
                        input logic [8:0] a, input logic [31:0] d);
      if (lat == 2) begin
         if2.MemRead = r; if2.MemWrite = w; if2.Funct3 = f3; if2.addr = a; if2.wd = d;
      end else begin
         if1.MemRead = r; if1.MemWrite = w; if1.Funct3 = f3; if1.addr = a; if1.wd = d;
      end
   endtask

   function automatic logic get_stall(input int lat);
      return (lat == 2) ? if2.stall : if1.stall;
   endfunction

   function automatic logic [31:0] get_rd(input int lat);
      return (lat == 2) ? if2.rd : if1.rd;
   endfunction

   function automatic logic get_err(input int lat);
      return (lat == 2) ? if2.access_err : if1.access_err;
   endfunction

   // Entered and left at a sample point (#1 after posedge) with the DUT in IDLE.
   task automatic access(input int lat, input vec_t v, input int tag);
      int   done_k;
      exp_t e;
      drive(lat, v.r, v.w, v.f3, v.a, v.d);
      sb_q.push_back('{rd: v.exp_rd, err: v.exp_err});
      #1;
      check("req_stall", tag, 32'(get_stall(lat)), 32'd1);
      done_k = 0;
      for (int k = 1; k <= lat + 3; k++) begin
         @(posedge clk); #1;
         if (!get_stall(lat)) begin
            done_k = k;
            break;
         end
         check("busy_err", tag, 32'(get_err(lat)), 32'd0);
      end
      check("latency", tag, done_k, lat);
      if (done_k != 0) begin
         e = sb_q.pop_front();
         check("rd", tag, get_rd(lat), e.rd);
         check("err", tag, 32'(get_err(lat)), 32'(e.err));
      end
      drive(lat, 1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
      @(posedge clk); #1;
      check("idle_stall", tag, 32'(get_stall(lat)), 32'd0);
      check("idle_err", tag, 32'(get_err(lat)), 32'd0);
   endtask

   vec_t vecs[21];
   vec_t v1[4];

   initial begin
      // Main table, LATENCY = 2. Stores keep the previous rd.
      vecs[0]  = '{1'b0, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h00000000, 1'b0}; // sw
      vecs[1]  = '{1'b1, 1'b0, 3'b010, 9'h010, 32'h0,        32'hDEADBEEF, 1'b0}; // lw
      vecs[2]  = '{1'b0, 1'b1, 3'b000, 9'h013, 32'h00000080, 32'hDEADBEEF, 1'b0}; // sb
      vecs[3]  = '{1'b1, 1'b0, 3'b000, 9'h013, 32'h0,        32'hFFFFFF80, 1'b0}; // lb
      vecs[4]  = '{1'b1, 1'b0, 3'b100, 9'h013, 32'h0,        32'h00000080, 1'b0}; // lbu
      vecs[5]  = '{1'b1, 1'b0, 3'b010, 9'h010, 32'h0,        32'h80ADBEEF, 1'b0}; // lw
      vecs[6]  = '{1'b1, 1'b0, 3'b001, 9'h011, 32'h0,        32'h00000000, 1'b1}; // lh mis
      vecs[7]  = '{1'b0, 1'b1, 3'b010, 9'h012, 32'h11112222, 32'h00000000, 1'b1}; // sw mis
      vecs[8]  = '{1'b1, 1'b0, 3'b010, 9'h010, 32'h0,        32'h80ADBEEF, 1'b0}; // lw
      vecs[9]  = '{1'b1, 1'b1, 3'b010, 9'h010, 32'h00000000, 32'h00000000, 1'b1}; // both
      vecs[10] = '{1'b1, 1'b0, 3'b010, 9'h010, 32'h0,        32'h80ADBEEF, 1'b0}; // lw
      vecs[11] = '{1'b1, 1'b0, 3'b011, 9'h010, 32'h0,        32'h00000000, 1'b1}; // f3=011
      vecs[12] = '{1'b0, 1'b1, 3'b010, 9'h014, 32'h00000000, 32'h00000000, 1'b0}; // sw 0
      vecs[13] = '{1'b0, 1'b1, 3'b001, 9'h016, 32'h1234A5C3, 32'h00000000, 1'b0}; // sh hi
      vecs[14] = '{1'b1, 1'b0, 3'b001, 9'h016, 32'h0,        32'hFFFFA5C3, 1'b0}; // lh
      vecs[15] = '{1'b1, 1'b0, 3'b101, 9'h016, 32'h0,        32'h0000A5C3, 1'b0}; // lhu
      vecs[16] = '{1'b1, 1'b0, 3'b001, 9'h014, 32'h0,        32'h00000000, 1'b0}; // lh lo
      vecs[17] = '{1'b1, 1'b0, 3'b100, 9'h017, 32'h0,        32'h000000A5, 1'b0}; // lbu
      vecs[18] = '{1'b0, 1'b1, 3'b100, 9'h014, 32'hFFFFFFFF, 32'h00000000, 1'b1}; // "sbu"
      vecs[19] = '{1'b1, 1'b0, 3'b010, 9'h014, 32'h0,        32'hA5C30000, 1'b0}; // lw
      vecs[20] = '{1'b0, 1'b1, 3'b010, 9'h020, 32'hCAFEF00D, 32'hA5C30000, 1'b0}; // preload

      // LATENCY = 1: preload, then back-to-back lw / sw / lw.
      v1[0] = '{1'b0, 1'b1, 3'b010, 9'h030, 32'h0BADF00D, 32'h00000000, 1'b0};
      v1[1] = '{1'b1, 1'b0, 3'b010, 9'h030, 32'h0,        32'h0BADF00D, 1'b0};
      v1[2] = '{1'b0, 1'b1, 3'b010, 9'h030, 32'h55AA33CC, 32'h0BADF00D, 1'b0};
      v1[3] = '{1'b1, 1'b0, 3'b010, 9'h030, 32'h0,        32'h55AA33CC, 1'b0};

      drive(2, 1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
      drive(1, 1'b1, 1'b0, 3'b010, 9'h000, 32'h0); // request held during reset
      repeat (3) @(posedge clk);
      #1;
      check("rst_rd", 0, if2.rd, 32'h0);
      check("rst_err", 0, 32'(if2.access_err), 32'd0);
      check("rst_stall", 0, 32'(if2.stall), 32'd0);
      check("rst_stall_req", 1, 32'(if1.stall), 32'd0);
      drive(1, 1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 21; i++) access(2, vecs[i], i);

      // Reset pulsed while a store is in BUSY: it must not commit.
      drive(2, 1'b0, 1'b1, 3'b010, 9'h020, 32'h12345678);
      #1;
      check("abort_req_stall", 100, 32'(if2.stall), 32'd1);
      @(posedge clk); #1;
      check("abort_busy_stall", 100, 32'(if2.stall), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_stall", 100, 32'(if2.stall), 32'd0);
      check("abort_rd", 100, if2.rd, 32'h0);
      check("abort_err", 100, 32'(if2.access_err), 32'd0);
      drive(2, 1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      access(2, '{1'b1, 1'b0, 3'b010, 9'h020, 32'h0, 32'hCAFEF00D, 1'b0}, 101);

      for (int i = 0; i < 4; i++) access(1, v1[i], 200 + i);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
